pwm_capture: RTL and testbench

//  Measures an incoming PWM waveform (servo-style, 50 Hz, 0.5-2.5 ms pulses) and reports pulse width,

---
 rtl/pwm_capture.sv | 206 ++++++++++++++++++++
 tb/tb_pwm_capture.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and duty (high*1024/period) of an asynchronous PWM input.
// Defining PWM_GLITCH_FILTER_EN inserts a FILTER_CYC-cycle stability filter after the synchronizer.
module pwm_capture #(
   parameter int unsigned TIMEOUT_CYC = 4_000_000,
   parameter int unsigned MIN_PERIOD  = 16,
   parameter int unsigned FILTER_CYC  = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        pwm_i,
   output logic [9:0]  duty_o,
   output logic [31:0] high_cnt_o,
   output logic [31:0] period_cnt_o,
   output logic        valid_o,
   output logic        signal_lost_o
);

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   // The divider needs 10 cycles plus launch; shorter periods would overlap two divisions.
   if (MIN_PERIOD < 12 || FILTER_CYC == 0) begin : g_bad_param
      $error("pwm_capture: MIN_PERIOD must be >= 12 and FILTER_CYC >= 1");
   end

   logic sync1_q, sync2_q, prev_q, rise_q, fall_q;
   logic flt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= pwm_i;
         sync2_q <= sync1_q;
         prev_q  <= flt;
         rise_q  <= flt & ~prev_q;
         fall_q  <= ~flt & prev_q;
      end
   end

`ifdef PWM_GLITCH_FILTER_EN
   localparam int unsigned FW = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;

   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          filt_q, filt_d;

   always_comb begin
      fcnt_d = '0;
      filt_d = filt_q;
      if (sync2_q != filt_q) begin
         if (fcnt_q == FW'(FILTER_CYC - 1)) filt_d = sync2_q;
         else                               fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fcnt_q <= '0;
         filt_q <= 1'b0;
      end else begin
         fcnt_q <= fcnt_d;
         filt_q <= filt_d;
      end
   end

   assign flt = filt_q;
`else
   assign flt = sync2_q;
`endif

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d, h_q, h_d;
   logic        start_div, lost_set;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      h_d       = h_q;
      start_div = 1'b0;
      lost_set  = 1'b0;
      if (state_q != StIdle) cnt_d = cnt_q + 32'd1;
      case (state_q)
         StIdle: begin
            if (rise_q) begin
               state_d = StHigh;
               cnt_d   = 32'd1;
            end
         end
         StHigh: begin
            if (fall_q) begin
               state_d = StLow;
               h_d     = cnt_q;
            end
         end
         StLow: begin
            if (rise_q) begin
               state_d   = StHigh;
               cnt_d     = 32'd1;
               start_div = (cnt_q >= MIN_PERIOD);
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_q != StIdle && cnt_q >= TIMEOUT_CYC) begin
         state_d   = StIdle;
         cnt_d     = '0;
         start_div = 1'b0;
         lost_set  = 1'b1;
      end
   end

   logic        busy_q, busy_d, valid_q, valid_d, lost_q, lost_d;
   logic [3:0]  step_q, step_d;
   logic [31:0] rem_q, rem_d, dh_q, dh_d, dp_q, dp_d;
   logic [32:0] rem2;
   logic [9:0]  quo_q, quo_d, duty_q, duty_d;
   logic [31:0] high_q, high_d, per_q, per_d;

   // Restoring division of h*1024 by p: since h < p, seeding the remainder with h
   // leaves exactly 10 quotient bits to produce.
   always_comb begin
      busy_d  = busy_q;
      step_d  = step_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dh_d    = dh_q;
      dp_d    = dp_q;
      duty_d  = duty_q;
      high_d  = high_q;
      per_d   = per_q;
      valid_d = 1'b0;
      rem2    = {rem_q, 1'b0};
      if (busy_q) begin
         if (rem2 >= {1'b0, dp_q}) begin
            rem_d = 32'(rem2 - {1'b0, dp_q});
            quo_d = {quo_q[8:0], 1'b1};
         end else begin
            rem_d = rem2[31:0];
            quo_d = {quo_q[8:0], 1'b0};
         end
         step_d = step_q + 4'd1;
         if (step_q == 4'd9) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
            duty_d  = quo_d;
            high_d  = dh_q;
            per_d   = dp_q;
         end
      end
      if (start_div) begin
         busy_d = 1'b1;
         step_d = '0;
         rem_d  = h_q;
         quo_d  = '0;
         dh_d   = h_q;
         dp_d   = cnt_q;
      end
      lost_d = lost_q;
      if (valid_d)  lost_d = 1'b0;
      if (lost_set) lost_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         h_q     <= '0;
         busy_q  <= 1'b0;
         step_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dh_q    <= '0;
         dp_q    <= '0;
         duty_q  <= '0;
         high_q  <= '0;
         per_q   <= '0;
         valid_q <= 1'b0;
         lost_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         h_q     <= h_d;
         busy_q  <= busy_d;
         step_q  <= step_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dh_q    <= dh_d;
         dp_q    <= dp_d;
         duty_q  <= duty_d;
         high_q  <= high_d;
         per_q   <= per_d;
         valid_q <= valid_d;
         lost_q  <= lost_d;
      end
   end

   assign duty_o        = duty_q;
   assign high_cnt_o    = high_q;
   assign period_cnt_o  = per_q;
   assign valid_o       = valid_q;
   assign signal_lost_o = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM waveforms into pwm_capture and checks every valid pulse against
// a waveform-level model (rise/fall times -> high, period, duty, latency).
module tb_pwm_capture;
   localparam int TIMEOUT = 5000;
   localparam int MINP    = 16;
   localparam int FILT    = 8;
`ifdef PWM_GLITCH_FILTER_EN
   localparam int FDLY = FILT;
`else
   localparam int FDLY = 0;
`endif
   // pwm_i change -> valid: 3 cycles edge detection, 11 cycles measurement
   localparam int LAT  = 14 + FDLY;
   localparam int LOGN = 65536;

   typedef struct {
      int unsigned c;
      int unsigned d;
      int unsigned h;
      int unsigned p;
      logic        lost;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pwm = 1'b0;
   logic [9:0]  duty;
   logic [31:0] high, period;
   logic        valid, lost;

   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   ev_t         evq[$];
   logic        wave[$];
   logic        lost_log [LOGN];

   pwm_capture #(
      .TIMEOUT_CYC(TIMEOUT),
      .MIN_PERIOD (MINP),
      .FILTER_CYC (FILT)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .pwm_i        (pwm),
      .duty_o       (duty),
      .high_cnt_o   (high),
      .period_cnt_o (period),
      .valid_o      (valid),
      .signal_lost_o(lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(int unsigned c, int unsigned d, int unsigned h, int unsigned p,
                              logic l);
      ev_t e;
      e.c = c; e.d = d; e.h = h; e.p = p; e.lost = l;
      return e;
   endfunction

   always @(negedge clk) begin
      if (valid) evq.push_back(mk(cyc, int'(duty), high, period, lost));
      if (cyc < LOGN) lost_log[cyc] <= lost;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pwm = 1'b0;
      rst_n = 1'b0;
      wave.delete();
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(3);
      evq.delete();
   endtask

   task automatic add_seg(input logic lvl, input int len);
      for (int i = 0; i < len; i++) wave.push_back(lvl);
   endtask

   task automatic add_pulse(input int h, input int p);
      add_seg(1'b1, h);
      add_seg(1'b0, p - h);
   endtask

   task automatic chk(input string name, input int unsigned got, input int unsigned want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Drives the queued waveform one level per cycle, then compares captured valid pulses
   // with those predicted from the waveform's own edges.
   task automatic run_wave(input string name, output int unsigned s);
      logic fw[$];
      ev_t  exq[$];
      logic lvl;
      bit   armed, stable;
      int   n, prev_rise, fall, p, h;
      n = wave.size();
      lvl = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (wave[i] != lvl) begin
            stable = 1'b1;
            for (int k = 0; k < FDLY; k++)
               if (i + k >= n || wave[i + k] != wave[i]) stable = 1'b0;
            if (stable) lvl = wave[i];
         end
         fw.push_back(lvl);
      end
      s = cyc;
      for (int i = 0; i < n; i++) begin
         pwm = wave[i];
         wait_cyc(1);
      end
      armed = 1'b0;
      prev_rise = 0;
      fall = 0;
      for (int i = 1; i < n; i++) begin
         if (fw[i] && !fw[i-1]) begin
            p = i - prev_rise;
            h = fall - prev_rise;
            if (armed && p < TIMEOUT && p >= MINP)
               exq.push_back(mk(s + i + LAT, h * 1024 / p, h, p, 1'b0));
            armed = 1'b1;
            prev_rise = i;
         end else if (!fw[i] && fw[i-1]) begin
            fall = i;
         end
      end
      total++;
      if (evq.size() != exq.size()) begin
         bad++;
         $display("FAIL %s valid_count: got %0d want %0d", name, evq.size(), exq.size());
      end
      for (int i = 0; i < exq.size() && i < evq.size(); i++) begin
         total++;
         if (evq[i].c !== exq[i].c || evq[i].d !== exq[i].d || evq[i].h !== exq[i].h ||
             evq[i].p !== exq[i].p || evq[i].lost !== 1'b0) begin
            bad++;
            $display("FAIL %s valid[%0d]: got cyc=%0d duty=%0d high=%0d period=%0d lost=%0b want cyc=%0d duty=%0d high=%0d period=%0d lost=0",
                     name, i, evq[i].c, evq[i].d, evq[i].h, evq[i].p, evq[i].lost,
                     exq[i].c, exq[i].d, exq[i].h, exq[i].p);
         end
      end
   endtask

   task automatic chk_lost(input string name, input int unsigned at, input logic want);
      total++;
      if (at >= LOGN) begin
         bad++;
         $display("FAIL %s: cycle %0d outside log, want lost=%0b", name, at, want);
      end else if (lost_log[at] !== want) begin
         bad++;
         $display("FAIL %s: got lost=%0b want %0b at cycle %0d", name, lost_log[at], want, at);
      end
   endtask

   task automatic test_reset();
      wait_cyc(2);
      chk("rst_duty", duty, 0);
      chk("rst_high", high, 0);
      chk("rst_period", period, 0);
      chk("rst_valid", valid, 0);
      chk("rst_lost", lost, 1);
      rst_n = 1'b1;
      wait_cyc(5);
      chk("post_rst_duty", duty, 0);
      chk("post_rst_period", period, 0);
      chk("post_rst_valid_seen", evq.size(), 0);
      chk("post_rst_lost", lost, 1);
   endtask

   task automatic test_servo_duty();
      int unsigned s;
      do_reset();
      add_seg(1'b0, 10);
      repeat (3) add_pulse(150, 2000);
      repeat (2) add_pulse(50, 2000);
      repeat (2) add_pulse(250, 2000);
      add_seg(1'b1, 20);
      add_seg(1'b0, LAT + 20);
      run_wave("servo", s);
      chk("servo_last_duty", duty, 128);
   endtask

   task automatic test_random();
      int unsigned s;
      int p;
      do_reset();
      add_seg(1'b0, 10);
      for (int i = 0; i < 14; i++) begin
         p = int'($urandom_range(700, 32));
         add_pulse(int'($urandom_range(p - 10, 10)), p);
      end
      add_seg(1'b1, 20);
      add_seg(1'b0, LAT + 20);
      run_wave("random", s);
   endtask

   task automatic test_timeout();
      int unsigned s;
      int rh, ra;
      do_reset();
      add_seg(1'b0, 10);
      repeat (3) add_pulse(250, 1000);
      rh = wave.size();
      add_seg(1'b1, 5100);
      add_seg(1'b0, 750);
      ra = wave.size();
      repeat (2) add_pulse(250, 1000);
      add_seg(1'b1, 20);
      add_seg(1'b0, LAT + 20);
      run_wave("timeout", s);
      chk_lost("lost_before_timeout", s + rh + TIMEOUT - 20, 1'b0);
      chk_lost("lost_after_timeout", s + rh + TIMEOUT + 40, 1'b1);
      chk_lost("lost_after_arm_rise", s + ra + LAT + 20, 1'b1);
      chk_lost("lost_cleared", s + ra + 1000 + LAT, 1'b0);
      chk_lost("lost_before_clear", s + ra + 1000 + LAT - 1, 1'b1);
   endtask

   task automatic test_short_period();
      int unsigned s;
      do_reset();
      add_seg(1'b0, 10);
      repeat (2) add_pulse(500, 1000);
      add_pulse(2, 5);
      add_pulse(500, 1000);
      add_seg(1'b1, 20);
      add_seg(1'b0, LAT + 20);
      run_wave("short_period", s);
   endtask

   task automatic test_glitch();
      int unsigned s;
      do_reset();
      add_seg(1'b0, 10);
      add_pulse(500, 1000);
      add_seg(1'b1, 500);
      add_seg(1'b0, 200);
      add_seg(1'b1, 3);
      add_seg(1'b0, 297);
      add_pulse(500, 1000);
      add_seg(1'b1, 20);
      add_seg(1'b0, LAT + 20);
      run_wave("glitch", s);
   endtask

   task automatic test_reset_mid_div();
      do_reset();
      pwm = 1'b1;
      wait_cyc(100);
      pwm = 1'b0;
      wait_cyc(100);
      pwm = 1'b1;
      wait_cyc(100);
      pwm = 1'b0;
      wait_cyc(100);
      pwm = 1'b1;
      wait_cyc(LAT - 5);
      chk("middiv_prior_valids", evq.size(), 1);
      chk("middiv_prior_duty", duty, 512);
      rst_n = 1'b0;
      #1;
      chk("middiv_duty", duty, 0);
      chk("middiv_high", high, 0);
      chk("middiv_period", period, 0);
      chk("middiv_valid", valid, 0);
      chk("middiv_lost", lost, 1);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(LAT + 30);
      chk("middiv_no_valid_after", evq.size(), 1);
      chk("middiv_lost_after", lost, 1);
      pwm = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_servo_duty();
      test_random();
      test_timeout();
      test_short_period();
      test_glitch();
      test_reset_mid_div();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no end of test want finish before 5 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
